// File: rtl/disparity_search_ctrl.sv
// Per-pixel disparity sweep controller: issues candidates 0..MAX_DISP-1, keeps a running minimum
// of the returned window sums. Define DISP_CONF_EN to add second-best tracking and the low_conf flag.
module disparity_search_ctrl #(
    parameter int MAX_DISP    = 64,
    parameter int DISP_W      = 6,
    parameter int WS_W        = 14,
    parameter int CONF_MARGIN = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              cand_valid,
    input  logic              cand_ready,
    output logic [DISP_W-1:0] cand_disp,
    input  logic              ws_valid,
    input  logic [WS_W-1:0]   ws_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DISP_W-1:0] disparity,
    output logic [WS_W-1:0]   window_sum,
    output logic              low_conf,
    output logic              busy
);

    // One extra bit so counters can hold MAX_DISP when MAX_DISP == 2**DISP_W.
    localparam int CNT_W = DISP_W + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(MAX_DISP - 1);
    localparam logic [DISP_W-1:0] LAST_DISP = DISP_W'(MAX_DISP - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, RESULT} state_t;

    state_t            state_reg, state_next;
    logic              cand_valid_reg;
    logic [DISP_W-1:0] cand_disp_reg;
    logic [CNT_W-1:0]  issue_cnt_reg, rcv_cnt_reg;
    logic [WS_W-1:0]   best_ws_reg, best_ws_next;
    logic [DISP_W-1:0] best_disp_reg, best_disp_next;
    logic [DISP_W-1:0] disparity_reg;
    logic [WS_W-1:0]   window_sum_reg;

    logic pix_hs, cand_hs, last_cand, ws_acc, last_ret, take_new;

    assign pix_hs    = pix_valid && (state_reg == IDLE);
    assign cand_hs   = cand_valid_reg && cand_ready;
    assign last_cand = cand_hs && (cand_disp_reg == LAST_DISP);
    // Returns beyond what has been issued (or outside a sweep) are stale and dropped.
    assign ws_acc    = ws_valid && ((state_reg == SWEEP) || (state_reg == DRAIN))
                       && (rcv_cnt_reg < issue_cnt_reg);
    assign last_ret  = ws_acc && (rcv_cnt_reg == LAST_CNT);
    assign take_new  = ws_acc && ((rcv_cnt_reg == '0) || (ws_in < best_ws_reg));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (pix_valid) state_next = SWEEP;
            SWEEP:  if (last_cand) state_next = last_ret ? RESULT : DRAIN;
            DRAIN:  if (last_ret) state_next = RESULT;
            RESULT: if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pix_ready = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state_reg)
            IDLE: begin
                pix_ready = 1'b1;
                busy      = 1'b0;
            end
            RESULT:  res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cand_valid_reg <= 1'b0;
            cand_disp_reg  <= '0;
            issue_cnt_reg  <= '0;
            rcv_cnt_reg    <= '0;
        end else if (pix_hs) begin
            cand_valid_reg <= 1'b1;
            cand_disp_reg  <= '0;
            issue_cnt_reg  <= '0;
            rcv_cnt_reg    <= '0;
        end else begin
            if (cand_hs) begin
                cand_disp_reg <= cand_disp_reg + 1'b1;
                issue_cnt_reg <= issue_cnt_reg + 1'b1;
            end
            if (last_cand) cand_valid_reg <= 1'b0;
            if (ws_acc) rcv_cnt_reg <= rcv_cnt_reg + 1'b1;
        end
    end

    // Strict less-than keeps the lower disparity on ties.
    always_comb begin
        best_ws_next   = best_ws_reg;
        best_disp_next = best_disp_reg;
        if (take_new) begin
            best_ws_next   = ws_in;
            best_disp_next = rcv_cnt_reg[DISP_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            best_ws_reg    <= '0;
            best_disp_reg  <= '0;
            disparity_reg  <= '0;
            window_sum_reg <= '0;
        end else begin
            best_ws_reg   <= best_ws_next;
            best_disp_reg <= best_disp_next;
            if (last_ret) begin
                disparity_reg  <= best_disp_next;
                window_sum_reg <= best_ws_next;
            end
        end
    end

`ifdef DISP_CONF_EN
    logic [WS_W-1:0] second_ws_reg, second_ws_next;
    logic [WS_W:0]   gap_next;
    logic            low_conf_reg;

    // The first return only seeds the best; second-best stays at all-ones until beaten.
    always_comb begin
        second_ws_next = second_ws_reg;
        if (ws_acc && (rcv_cnt_reg != '0)) begin
            if (ws_in < best_ws_reg) begin
                second_ws_next = best_ws_reg;
            end else if (ws_in < second_ws_reg) begin
                second_ws_next = ws_in;
            end
        end
        gap_next = {1'b0, second_ws_next} - {1'b0, best_ws_next};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            second_ws_reg <= '1;
            low_conf_reg  <= 1'b0;
        end else begin
            if (pix_hs) begin
                second_ws_reg <= '1;
            end else begin
                second_ws_reg <= second_ws_next;
            end
            if (last_ret) low_conf_reg <= (gap_next < (WS_W+1)'(CONF_MARGIN));
        end
    end

    assign low_conf = low_conf_reg;
`else
    assign low_conf = 1'b0;
`endif

    assign cand_valid = cand_valid_reg;
    assign cand_disp  = cand_disp_reg;
    assign disparity  = disparity_reg;
    assign window_sum = window_sum_reg;

endmodule

// File: doc/disparity_search_ctrl.md
# disparity_search_ctrl

Per-pixel disparity sweep controller for the stereo depth pipeline. It accepts one pixel job at a time, issues every candidate disparity 0..MAX_DISP-1 to the SAD window-sum unit, and consumes the returned window sums in order. It keeps a running minimum with lowest-disparity tie-breaking, which sequences the min-select datapath across the full search range. The winning disparity and window sum are presented on a valid/ready result port to the depth-map writer.

## Interface
- MAX_DISP, 64: number of candidates per pixel; range 1..2^DISP_W.
- DISP_W, 6: disparity width.
- WS_W, 14: window-sum width.
- CONF_MARGIN, 16: minimum best-to-second-best gap; used only with DISP_CONF_EN.

Ports:
- clock  in  1  rising-edge clock; the block's only clock.
- reset_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  request to start a sweep for the next pixel.
- pix_ready  out  1  high exactly in IDLE; handshake when pix_valid && pix_ready.
- cand_valid  out  1  a candidate request is presented.
- cand_ready  in  1  SAD unit accepts the candidate.
- cand_disp  out  DISP_W  candidate disparity being requested.
- ws_valid  in  1  window-sum return strobe; returns arrive in issue order; no backpressure.
- ws_in  in  WS_W  returned window sum.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- disparity  out  DISP_W  winning disparity.
- window_sum  out  WS_W  winning window sum.
- low_conf  out  1  ambiguous match flag; tied 0 without DISP_CONF_EN.
- busy  out  1  high in SWEEP, DRAIN or RESULT.

## Operation
- FSM states:
  - IDLE: pix handshake → SWEEP.
  - SWEEP: cand_valid=1. Each cand handshake increments issue_cnt and cand_disp. The handshake with cand_disp==MAX_DISP-1 → DRAIN, or → RESULT if that final return is also accepted in the same cycle.
  - DRAIN: cand_valid=0. The cycle accepting return number MAX_DISP-1 → RESULT.
  - RESULT: res_valid=1. Res handshake → IDLE.
- Returns:
  - rcv_cnt counts accepted ws_valid strobes and is the disparity of the current ws_in.
  - ws_valid is accepted only in SWEEP/DRAIN and only while rcv_cnt < issue_cnt. All other strobes are ignored.
- Running minimum:
  - First return (rcv_cnt==0) loads best_ws=ws_in, best_disp=0.
  - Later returns: if ws_in < best_ws (strict), load ws_in and rcv_cnt. Otherwise hold, so ties keep the lower disparity.
  - Unsigned compare at WS_W bits.
- cand_disp and cand_valid are registered. cand_disp holds while cand_valid && !cand_ready.
- disparity, window_sum and low_conf are loaded on RESULT entry and held stable until the res handshake.
- pix_valid is ignored outside IDLE. res_ready is ignored outside RESULT.
- Counters are reset to 0 on every pix handshake.
- Reset values, including reset asserted mid-sweep: state IDLE, pix_ready 1, cand_valid 0, cand_disp 0, res_valid 0, disparity 0, window_sum 0, low_conf 0, busy 0, all counters 0.
  - A sweep interrupted by reset is abandoned. Its stale returns are ignored in IDLE.

## Timing
- Pix handshake at cycle T → busy=1 and cand_valid=1 with cand_disp=0 at T+1.
- With cand_ready held high: one candidate per cycle, issued T+1..T+MAX_DISP.
- The final return is accepted at cycle L → res_valid=1 at L+1, with results valid the same cycle.
- Res handshake at R → IDLE with pix_ready=1 at R+1. The next pix handshake can occur at R+1.
- Issue and return overlap freely. Outstanding depth is unbounded up to MAX_DISP.

## Configuration
- DISP_CONF_EN defined:
  - Also tracks second_ws, reset to all-ones at sweep start.
  - On a best update: second_ws ← old best_ws.
  - Otherwise, if ws_in < second_ws: second_ws ← ws_in.
  - At RESULT entry: low_conf = (second_ws − best_ws) < CONF_MARGIN, computed at WS_W+1 bits.
- DISP_CONF_EN undefined: no second-best logic; low_conf constant 0.

## Test plan
- Reset: assert reset_n=0 at any point → all outputs at the listed reset values, pix_ready=1. A stray ws_valid pulse in IDLE leaves all outputs unchanged.
- Sweep and tie-break: MAX_DISP=8, cand_ready=1, returns 3 cycles after issue with sums 900,700,650,800,650,1000,720,999 → disparity 2, window_sum 650. With DISP_CONF_EN, low_conf=1 (gap 0).
- Candidate backpressure: cand_ready toggles 1/0 every cycle → cand_disp steps 0..7 only on handshakes, each value issued exactly once, cand_disp stable while stalled. Result matches an unstalled run.
- Result backpressure: res_ready low for 5 cycles → res_valid, disparity and window_sum stable, pix_ready=0, pix_valid ignored. res_ready=1 → IDLE next cycle.
- Mid-sweep reset: reset asserted after 3 of 8 returns → reset values. A following pixel with sums 50,40,30,20,10,60,70,80 → disparity 4, window_sum 10.
- Confidence (DISP_CONF_EN, CONF_MARGIN=16):
  - Best 300, second 310 → low_conf=1.
  - Best 300, second 400 → low_conf=0.
  - MAX_DISP=1 with sum 16382 → low_conf=1.
  - Without the macro, low_conf=0 in every case.
